// File: rtl/rv_pkg.sv
// Shared constants and types for the register-file writeback path.
package rv_pkg;
  localparam int NREG = 32;
  localparam int AW   = 6;
  localparam int DW   = 32;
  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_req_t;

  typedef enum logic {PTR_A = 1'b0, PTR_B = 1'b1} rr_ptr_t;

  function automatic logic rd_legal(logic [AW-1:0] rd);
    return 32'(rd) < NREG;
  endfunction
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback requesters, issue/check ports and register-file write port.
interface rf_wb_arbiter_if import rv_pkg::*; #(
  parameter int AW = rv_pkg::AW,
  parameter int DW = rv_pkg::DW
);
  logic          a_valid, a_ready;
  logic [AW-1:0] a_rd;
  logic [DW-1:0] a_data;
  logic          b_valid, b_ready;
  logic [AW-1:0] b_rd;
  logic [DW-1:0] b_data;
  logic          iss_valid;
  logic [AW-1:0] iss_rd, chk_rs1, chk_rs2;
  logic          hazard;
  logic          RegWrite;
  logic [AW-1:0] wr_reg;
  logic [DW-1:0] wr_data;
  logic          addr_err;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
           iss_valid, iss_rd, chk_rs1, chk_rs2,
    input  a_ready, b_ready, hazard, RegWrite, wr_reg, wr_data, addr_err
  );
  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
           iss_valid, iss_rd, chk_rs1, chk_rs2,
    output a_ready, b_ready, hazard, RegWrite, wr_reg, wr_data, addr_err
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending-write bits; set wins over clear, x0 never busy.
module rf_scoreboard import rv_pkg::*; #(
  parameter int NREG = rv_pkg::NREG,
  parameter int AW   = rv_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_rd,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_rd,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  output logic          hazard
);
  localparam int IW = $clog2(NREG);

  logic [NREG-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en && rd_legal(clr_rd)) busy_d[clr_rd[IW-1:0]] = 1'b0;
    if (set_en && rd_legal(set_rd)) busy_d[set_rd[IW-1:0]] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  // Out-of-range check addresses alias onto real bits, so gate them off.
  assign hazard = (rd_legal(rs1) & busy_q[rs1[IW-1:0]]) |
                  (rd_legal(rs2) & busy_q[rs2[IW-1:0]]);
endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin share of the register-file write port between ALU (A) and LSU (B),
// with registered commit, sticky address-error flag and RAW scoreboard.
module rf_wb_arbiter import rv_pkg::*; #(
  parameter int NREG = rv_pkg::NREG,
  parameter int AW   = rv_pkg::AW,
  parameter int DW   = rv_pkg::DW
) (
  input  logic           clk,
  input  logic           rst,
  rf_wb_arbiter_if.slave wb
);
  rr_ptr_t       ptr_q, ptr_d;
  logic          regwrite_q, regwrite_d;
  logic [AW-1:0] wr_reg_q, wr_reg_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          addr_err_q, addr_err_d;
  logic          grant_a, grant_b, win_legal, iss_legal;
  wb_req_t       win;

  always_comb begin
    grant_a = wb.a_valid & (!wb.b_valid | (ptr_q == PTR_A));
    grant_b = wb.b_valid & (!wb.a_valid | (ptr_q == PTR_B));

    win.valid = grant_a | grant_b;
    win.rd    = grant_a ? wb.a_rd   : wb.b_rd;
    win.data  = grant_a ? wb.a_data : wb.b_data;
    win_legal = rd_legal(win.rd);
    iss_legal = rd_legal(wb.iss_rd);

    ptr_d = ptr_q;
    if (grant_a)      ptr_d = PTR_B;
    else if (grant_b) ptr_d = PTR_A;

    // x0 and illegal writes are consumed but never reach the register file.
    regwrite_d = win.valid & win_legal & (win.rd != REG_ZERO);
    wr_reg_d   = regwrite_d ? win.rd   : wr_reg_q;
    wr_data_d  = regwrite_d ? win.data : wr_data_q;

    addr_err_d = addr_err_q | (win.valid & !win_legal) | (wb.iss_valid & !iss_legal);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q      <= PTR_A;
      regwrite_q <= 1'b0;
      wr_reg_q   <= '0;
      wr_data_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      regwrite_q <= regwrite_d;
      wr_reg_q   <= wr_reg_d;
      wr_data_q  <= wr_data_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign wb.a_ready  = grant_a;
  assign wb.b_ready  = grant_b;
  assign wb.RegWrite = regwrite_q;
  assign wb.wr_reg   = wr_reg_q;
  assign wb.wr_data  = wr_data_q;
  assign wb.addr_err = addr_err_q;

  // Busy clears at acceptance; the commit lands a cycle later.
  rf_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
    .clk    (clk),
    .rst    (rst),
    .set_en (wb.iss_valid),
    .set_rd (wb.iss_rd),
    .clr_en (win.valid),
    .clr_rd (win.rd),
    .rs1    (wb.chk_rs1),
    .rs2    (wb.chk_rs2),
    .hazard (wb.hazard)
  );
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter.
module tb_rf_wb_arbiter;
  import rv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cmp = 0;
  int   err = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.AW(AW), .DW(DW)) wb ();
  rf_wb_arbiter #(.NREG(NREG), .AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .wb(wb));

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs;
    wb.a_valid = 0; wb.a_rd = '0; wb.a_data = '0;
    wb.b_valid = 0; wb.b_rd = '0; wb.b_data = '0;
    wb.iss_valid = 0; wb.iss_rd = '0; wb.chk_rs1 = '0; wb.chk_rs2 = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 0;
    step(); step();
    rst = 1;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 0;
    wb.chk_rs1 = 6'd1; wb.chk_rs2 = 6'd2;
    step(); step();
    cmp++; if (wb.RegWrite !== 1'b0) begin err++; $display("FAIL reset_regwrite: got %b want 0", wb.RegWrite); end
    cmp++; if (wb.wr_reg !== 6'd0) begin err++; $display("FAIL reset_wr_reg: got %0d want 0", wb.wr_reg); end
    cmp++; if (wb.wr_data !== 32'd0) begin err++; $display("FAIL reset_wr_data: got %h want 0", wb.wr_data); end
    cmp++; if (wb.addr_err !== 1'b0) begin err++; $display("FAIL reset_addr_err: got %b want 0", wb.addr_err); end
    cmp++; if (wb.hazard !== 1'b0) begin err++; $display("FAIL reset_hazard: got %b want 0", wb.hazard); end
    rst = 1;
    idle_inputs();
  endtask

  task automatic test_single_a;
    wb.a_valid = 1; wb.a_rd = 6'd5; wb.a_data = 32'h0000_00AA;
    #1;
    cmp++; if (wb.a_ready !== 1'b1) begin err++; $display("FAIL single_a_ready: got %b want 1", wb.a_ready); end
    cmp++; if (wb.b_ready !== 1'b0) begin err++; $display("FAIL single_b_ready: got %b want 0", wb.b_ready); end
    step();
    wb.a_valid = 0;
    cmp++; if (wb.RegWrite !== 1'b1) begin err++; $display("FAIL single_regwrite: got %b want 1", wb.RegWrite); end
    cmp++; if (wb.wr_reg !== 6'd5) begin err++; $display("FAIL single_wr_reg: got %0d want 5", wb.wr_reg); end
    cmp++; if (wb.wr_data !== 32'hAA) begin err++; $display("FAIL single_wr_data: got %h want aa", wb.wr_data); end
    step();
    cmp++; if (wb.RegWrite !== 1'b0) begin err++; $display("FAIL single_regwrite_drop: got %b want 0", wb.RegWrite); end
    cmp++; if (wb.wr_reg !== 6'd5) begin err++; $display("FAIL single_wr_reg_hold: got %0d want 5", wb.wr_reg); end
  endtask

  task automatic test_contention;
    do_reset();
    wb.a_valid = 1; wb.a_rd = 6'd3; wb.a_data = 32'h33;
    wb.b_valid = 1; wb.b_rd = 6'd7; wb.b_data = 32'h77;
    #1;
    cmp++; if ({wb.a_ready, wb.b_ready} !== 2'b10) begin err++; $display("FAIL cont_first_grant: got %b want 10", {wb.a_ready, wb.b_ready}); end
    step();
    wb.a_valid = 0;
    cmp++; if (wb.RegWrite !== 1'b1 || wb.wr_reg !== 6'd3) begin err++; $display("FAIL cont_commit_a: got we=%b reg=%0d want we=1 reg=3", wb.RegWrite, wb.wr_reg); end
    #1;
    cmp++; if (wb.b_ready !== 1'b1) begin err++; $display("FAIL cont_second_grant: got %b want 1", wb.b_ready); end
    step();
    wb.b_valid = 0;
    cmp++; if (wb.RegWrite !== 1'b1 || wb.wr_reg !== 6'd7 || wb.wr_data !== 32'h77) begin err++; $display("FAIL cont_commit_b: got we=%b reg=%0d data=%h want we=1 reg=7 data=77", wb.RegWrite, wb.wr_reg, wb.wr_data); end
    // pointer is back on A after the B grant
    wb.a_valid = 1; wb.b_valid = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      cmp++; if (wb.a_ready !== (i % 2 == 0) || wb.b_ready !== (i % 2 == 1)) begin err++; $display("FAIL alt_grant[%0d]: got a=%b b=%b want a=%b", i, wb.a_ready, wb.b_ready, (i % 2 == 0)); end
      step();
      cmp++; if (wb.wr_reg !== ((i % 2 == 0) ? 6'd3 : 6'd7)) begin err++; $display("FAIL alt_commit[%0d]: got %0d want %0d", i, wb.wr_reg, (i % 2 == 0) ? 3 : 7); end
    end
    idle_inputs();
  endtask

  task automatic test_x0_illegal;
    wb.b_valid = 1; wb.b_rd = 6'd0; wb.b_data = 32'h55;
    #1;
    cmp++; if (wb.b_ready !== 1'b1) begin err++; $display("FAIL x0_ready: got %b want 1", wb.b_ready); end
    step();
    wb.b_valid = 0;
    cmp++; if (wb.RegWrite !== 1'b0) begin err++; $display("FAIL x0_regwrite: got %b want 0", wb.RegWrite); end
    cmp++; if (wb.wr_reg !== 6'd7 || wb.wr_data !== 32'h77) begin err++; $display("FAIL x0_hold: got reg=%0d data=%h want reg=7 data=77", wb.wr_reg, wb.wr_data); end
    wb.a_valid = 1; wb.a_rd = 6'd40; wb.a_data = 32'hDEAD;
    #1;
    cmp++; if (wb.a_ready !== 1'b1) begin err++; $display("FAIL illegal_ready: got %b want 1", wb.a_ready); end
    cmp++; if (wb.addr_err !== 1'b0) begin err++; $display("FAIL illegal_err_early: got %b want 0", wb.addr_err); end
    step();
    wb.a_valid = 0;
    cmp++; if (wb.RegWrite !== 1'b0) begin err++; $display("FAIL illegal_regwrite: got %b want 0", wb.RegWrite); end
    cmp++; if (wb.addr_err !== 1'b1) begin err++; $display("FAIL illegal_err_set: got %b want 1", wb.addr_err); end
    step(); step();
    cmp++; if (wb.addr_err !== 1'b1) begin err++; $display("FAIL illegal_err_sticky: got %b want 1", wb.addr_err); end
    cmp++; if (wb.wr_reg !== 6'd7) begin err++; $display("FAIL illegal_wr_reg_hold: got %0d want 7", wb.wr_reg); end
  endtask

  task automatic test_scoreboard;
    do_reset();
    wb.iss_valid = 1; wb.iss_rd = 6'd9; wb.chk_rs1 = 6'd9;
    #1;
    cmp++; if (wb.hazard !== 1'b0) begin err++; $display("FAIL sb_before_set: got %b want 0", wb.hazard); end
    step();
    wb.iss_valid = 0;
    #1;
    cmp++; if (wb.hazard !== 1'b1) begin err++; $display("FAIL sb_rs1_busy: got %b want 1", wb.hazard); end
    wb.chk_rs1 = 6'd0; wb.chk_rs2 = 6'd9;
    #1;
    cmp++; if (wb.hazard !== 1'b1) begin err++; $display("FAIL sb_rs2_busy: got %b want 1", wb.hazard); end
    wb.chk_rs1 = 6'd9; wb.chk_rs2 = 6'd0;
    wb.a_valid = 1; wb.a_rd = 6'd9; wb.a_data = 32'h99;
    #1;
    cmp++; if (wb.hazard !== 1'b1) begin err++; $display("FAIL sb_busy_during_grant: got %b want 1", wb.hazard); end
    step();
    wb.a_valid = 0;
    #1;
    cmp++; if (wb.hazard !== 1'b0) begin err++; $display("FAIL sb_cleared: got %b want 0", wb.hazard); end
    cmp++; if (wb.RegWrite !== 1'b1 || wb.wr_reg !== 6'd9) begin err++; $display("FAIL sb_commit: got we=%b reg=%0d want we=1 reg=9", wb.RegWrite, wb.wr_reg); end
    wb.iss_valid = 1; wb.iss_rd = 6'd0;
    step();
    wb.iss_valid = 0; wb.chk_rs1 = 6'd0;
    #1;
    cmp++; if (wb.hazard !== 1'b0) begin err++; $display("FAIL sb_x0_never_busy: got %b want 0", wb.hazard); end
    wb.iss_valid = 1; wb.iss_rd = 6'd8;
    step();
    wb.iss_valid = 0; wb.chk_rs1 = 6'd40;
    #1;
    cmp++; if (wb.hazard !== 1'b0) begin err++; $display("FAIL sb_illegal_check: got %b want 0", wb.hazard); end
    wb.chk_rs1 = 6'd8;
    #1;
    cmp++; if (wb.hazard !== 1'b1) begin err++; $display("FAIL sb_reg8_busy: got %b want 1", wb.hazard); end
    cmp++; if (wb.addr_err !== 1'b0) begin err++; $display("FAIL sb_err_clear: got %b want 0", wb.addr_err); end
    wb.iss_valid = 1; wb.iss_rd = 6'd41;
    step();
    wb.iss_valid = 0; wb.chk_rs1 = 6'd9;
    #1;
    cmp++; if (wb.addr_err !== 1'b1) begin err++; $display("FAIL sb_illegal_issue_err: got %b want 1", wb.addr_err); end
    cmp++; if (wb.hazard !== 1'b0) begin err++; $display("FAIL sb_illegal_issue_alias: got %b want 0", wb.hazard); end
    idle_inputs();
  endtask

  task automatic test_set_clear;
    do_reset();
    wb.iss_valid = 1; wb.iss_rd = 6'd12;
    step();
    wb.a_valid = 1; wb.a_rd = 6'd12; wb.a_data = 32'hC;
    #1;
    cmp++; if (wb.a_ready !== 1'b1) begin err++; $display("FAIL setclr_ready: got %b want 1", wb.a_ready); end
    step();
    wb.a_valid = 0; wb.iss_valid = 0; wb.chk_rs1 = 6'd12;
    #1;
    cmp++; if (wb.hazard !== 1'b1) begin err++; $display("FAIL setclr_busy: got %b want 1", wb.hazard); end
    cmp++; if (wb.RegWrite !== 1'b1 || wb.wr_reg !== 6'd12) begin err++; $display("FAIL setclr_commit: got we=%b reg=%0d want we=1 reg=12", wb.RegWrite, wb.wr_reg); end
    idle_inputs();
  endtask

  task automatic test_async_reset;
    do_reset();
    wb.iss_valid = 1; wb.iss_rd = 6'd4;
    wb.a_valid = 1; wb.a_rd = 6'd20; wb.a_data = 32'h2020;
    step();
    wb.iss_valid = 0; wb.a_valid = 0; wb.chk_rs1 = 6'd4;
    #1;
    cmp++; if (wb.RegWrite !== 1'b1 || wb.hazard !== 1'b1) begin err++; $display("FAIL arst_pre: got we=%b hz=%b want 1 1", wb.RegWrite, wb.hazard); end
    #1;
    rst = 0;
    #1;
    cmp++; if (wb.RegWrite !== 1'b0) begin err++; $display("FAIL arst_regwrite: got %b want 0", wb.RegWrite); end
    cmp++; if (wb.hazard !== 1'b0) begin err++; $display("FAIL arst_hazard: got %b want 0", wb.hazard); end
    cmp++; if (wb.wr_reg !== 6'd0) begin err++; $display("FAIL arst_wr_reg: got %0d want 0", wb.wr_reg); end
    #2;
    rst = 1;
    wb.a_valid = 1; wb.b_valid = 1;
    #1;
    cmp++; if ({wb.a_ready, wb.b_ready} !== 2'b10) begin err++; $display("FAIL arst_ptr_a: got %b want 10", {wb.a_ready, wb.b_ready}); end
    idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_contention();
    test_x0_illegal();
    test_scoreboard();
    test_set_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
